// File: rtl/bias_seq_ctrl_pkg.sv
// rtl/bias_seq_ctrl_pkg.sv - shared coefficient sizes and sequencer state encoding
// Contents: coefficient width, per-layer ROM depth / pass count, FSM state type,
// and a helper that sizes the ROM address bus (at least 1 bit, even for 1-word ROMs).
package bias_seq_ctrl_pkg;

    localparam int COEFF_WIDTH = 16;
    localparam int KERN_S_K_0  = 16;
    localparam int N_PASSES_0  = 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } seq_state_t;

    function automatic int addr_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bias_seq_ctrl_coeff_fifo2.sv
// rtl/bias_seq_ctrl_coeff_fifo2.sv - 2-entry coefficient FIFO with push/pop/count/head
// Ports:
//   clk_i, rst_ni     clock, asynchronous active-low reset
//   push_i, din_i     write one word (caller guarantees no overflow)
//   pop_i             drop the head word (caller guarantees count_o > 0)
//   count_o           occupancy 0..2
//   head_o            oldest word; holds its last value when empty
module coeff_fifo2 #(
    parameter int WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] din_i,
    output logic [1:0]       count_o,
    output logic [WIDTH-1:0] head_o
);

    logic [WIDTH-1:0] e0_q;
    logic [WIDTH-1:0] e1_q;
    logic [1:0]       count_q;

    // e0_q is always the head; e1_q only holds data when two words are stored.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            e0_q    <= '0;
            e1_q    <= '0;
            count_q <= 2'd0;
        end else begin
            case ({push_i, pop_i})
                2'b10: begin
                    if (count_q == 2'd0) e0_q <= din_i;
                    else                 e1_q <= din_i;
                    count_q <= count_q + 2'd1;
                end
                2'b01: begin
                    if (count_q == 2'd2) e0_q <= e1_q;
                    count_q <= count_q - 2'd1;
                end
                2'b11: begin
                    // Occupancy unchanged; the incoming word lands behind the survivor.
                    if (count_q == 2'd2) begin
                        e0_q <= e1_q;
                        e1_q <= din_i;
                    end else begin
                        e0_q <= din_i;
                    end
                end
                default: ;
            endcase
        end
    end

    assign count_o = count_q;
    assign head_o  = e0_q;

endmodule

// File: rtl/bias_seq_ctrl.sv
// rtl/bias_seq_ctrl.sv - sweeps a coefficient ROM N_PASSES times per start into an ap_fifo stream
// Ports:
//   ap_clk, ap_rst_n                       clock, asynchronous active-low reset
//   ap_start/ap_done/ap_idle/ap_ready      block-level handshake (ap_ready mirrors ap_done)
//   rom_address, rom_ce, rom_q             ROM read port, data valid the cycle after rom_ce
//   output_V_din/_full_n/_write            ap_fifo write side toward the bias FIFO
module bias_seq_ctrl
    import bias_seq_ctrl_pkg::*;
#(
    parameter int MEM_SIZE   = KERN_S_K_0,
    parameter int DATA_WIDTH = COEFF_WIDTH,
    parameter int N_PASSES   = N_PASSES_0,
    localparam int AW        = addr_bits(MEM_SIZE)
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst_n,
    input  logic                  ap_start,
    output logic                  ap_done,
    output logic                  ap_idle,
    output logic                  ap_ready,
    output logic [AW-1:0]         rom_address,
    output logic                  rom_ce,
    input  logic [DATA_WIDTH-1:0] rom_q,
    output logic [DATA_WIDTH-1:0] output_V_din,
    input  logic                  output_V_full_n,
    output logic                  output_V_write
);

    localparam int PW = addr_bits(N_PASSES);
    localparam logic [AW-1:0] ADDR_LAST = AW'(MEM_SIZE - 1);
    localparam logic [PW-1:0] PASS_LAST = PW'(N_PASSES - 1);

    seq_state_t      state_q;
    logic [AW-1:0]   addr_q;
    logic [PW-1:0]   pass_q;
    logic            inflight_q;
    logic [1:0]      count;
    logic [2:0]      occ_after_pop;

    // Words already owned by the buffer after this cycle's pop, counting the read in flight.
    // A new read is only issued when it is guaranteed a slot when its data returns.
    assign output_V_write = (count != 2'd0) && output_V_full_n;
    assign occ_after_pop  = {1'b0, count} + {2'b00, inflight_q} - {2'b00, output_V_write};
    assign rom_ce         = (state_q == S_RUN) && (occ_after_pop < 3'd2);
    assign rom_address    = addr_q;

    // The final word is the one leaving the buffer with nothing behind it and nothing in flight.
    assign ap_done  = (state_q == S_DRAIN) && !inflight_q && (count == 2'd1) && output_V_write;
    assign ap_ready = ap_done;
    assign ap_idle  = (state_q == S_IDLE);

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            pass_q     <= '0;
            inflight_q <= 1'b0;
        end else begin
            inflight_q <= rom_ce;
            case (state_q)
                S_IDLE: begin
                    if (ap_start) begin
                        state_q <= S_RUN;
                        addr_q  <= '0;
                        pass_q  <= '0;
                    end
                end
                S_RUN: begin
                    if (rom_ce) begin
                        if (addr_q == ADDR_LAST) begin
                            addr_q <= '0;
                            pass_q <= pass_q + PW'(1);
                            if (pass_q == PASS_LAST) state_q <= S_DRAIN;
                        end else begin
                            addr_q <= addr_q + AW'(1);
                        end
                    end
                end
                S_DRAIN: begin
                    if (ap_done) state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    coeff_fifo2 #(
        .WIDTH (DATA_WIDTH)
    ) u_buf (
        .clk_i   (ap_clk),
        .rst_ni  (ap_rst_n),
        .push_i  (inflight_q),
        .pop_i   (output_V_write),
        .din_i   (rom_q),
        .count_o (count),
        .head_o  (output_V_din)
    );

endmodule

// File: tb/tb_bias_seq_ctrl.sv
// tb/tb_bias_seq_ctrl.sv - self-checking bench for bias_seq_ctrl
module tb_bias_seq_ctrl;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // Instance A: MEM_SIZE=4, N_PASSES=2, ROM {10,20,30,40}
    logic        start_a = 1'b0;
    logic        full_a  = 1'b1;
    logic        done_a, idle_a, ready_a, ce_a, write_a;
    logic [1:0]  addr_a;
    logic [15:0] q_a = '0;
    logic [15:0] din_a;

    // Instance B: MEM_SIZE=1, N_PASSES=3, ROM {7}
    logic        start_b = 1'b0;
    logic        full_b  = 1'b1;
    logic        done_b, idle_b, ready_b, ce_b, write_b;
    logic [0:0]  addr_b;
    logic [15:0] q_b = '0;
    logic [15:0] din_b;

    int rom_a [4] = '{10, 20, 30, 40};

    always @(posedge clk) if (ce_a) q_a <= 16'(rom_a[addr_a]);
    always @(posedge clk) if (ce_b) q_b <= 16'd7;

    bias_seq_ctrl #(.MEM_SIZE(4), .DATA_WIDTH(16), .N_PASSES(2)) dut_a (
        .ap_clk          (clk),
        .ap_rst_n        (rst_n),
        .ap_start        (start_a),
        .ap_done         (done_a),
        .ap_idle         (idle_a),
        .ap_ready        (ready_a),
        .rom_address     (addr_a),
        .rom_ce          (ce_a),
        .rom_q           (q_a),
        .output_V_din    (din_a),
        .output_V_full_n (full_a),
        .output_V_write  (write_a)
    );

    bias_seq_ctrl #(.MEM_SIZE(1), .DATA_WIDTH(16), .N_PASSES(3)) dut_b (
        .ap_clk          (clk),
        .ap_rst_n        (rst_n),
        .ap_start        (start_b),
        .ap_done         (done_b),
        .ap_idle         (idle_b),
        .ap_ready        (ready_b),
        .rom_address     (addr_b),
        .rom_ce          (ce_b),
        .rom_q           (q_b),
        .output_V_din    (din_b),
        .output_V_full_n (full_b),
        .output_V_write  (write_b)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ce_a"},    32'(ce_a),    32'd0);
        chk({tag, "_write_a"}, 32'(write_a), 32'd0);
        chk({tag, "_done_a"},  32'(done_a),  32'd0);
        chk({tag, "_ready_a"}, 32'(ready_a), 32'd0);
        chk({tag, "_addr_a"},  32'(addr_a),  32'd0);
        chk({tag, "_din_a"},   32'(din_a),   32'd0);
        chk({tag, "_idle_a"},  32'(idle_a),  32'd1);
        chk({tag, "_ce_b"},    32'(ce_b),    32'd0);
        chk({tag, "_write_b"}, 32'(write_b), 32'd0);
        chk({tag, "_idle_b"},  32'(idle_b),  32'd1);
        chk({tag, "_din_b"},   32'(din_b),   32'd0);
    endtask

    // Reference: each run must deliver rom 0..3 twice, in order, exactly once each,
    // with never more than 2 words read but undelivered, no write while full_n=0,
    // and ap_done exactly on the delivery of the 8th word.
    task automatic run_a(input int full_pct, input int block_cycles, input bit hold, input int n_runs);
        int exp_q[$];
        int cyc        = 0;
        int runs       = 0;
        int issued     = 0;
        int written    = 0;
        int ce_blocked = 0;
        int done_cyc   = -10;
        for (int p = 0; p < 2; p++) for (int k = 0; k < 4; k++) exp_q.push_back(rom_a[k]);
        @(negedge clk);
        start_a = 1'b1;
        full_a  = 1'b1;
        while (runs < n_runs && cyc < 600) begin
            if (cyc > 0) begin
                start_a = hold;
                if (cyc <= block_cycles) full_a = 1'b0;
                else full_a = ($urandom_range(0, 99) < full_pct);
            end
            #1;
            if (cyc >= 1 && cyc <= block_cycles && ce_a) ce_blocked++;
            chk("write_gated_by_full", 32'(write_a & ~full_a), 32'd0);
            chk("ready_eq_done", 32'(ready_a), 32'(done_a));
            issued  += int'(ce_a);
            written += int'(write_a);
            chk("outstanding_le_2", 32'((issued - written) <= 2), 32'd1);
            if (write_a) begin
                if (exp_q.size() == 0) chk("extra_write", 32'd1, 32'd0);
                else chk("din_order", 32'(din_a), 32'(exp_q.pop_front()));
            end
            if (done_a) begin
                chk("done_with_last_write", 32'({write_a, exp_q.size() == 0}), 32'd3);
                chk("reads_per_run", 32'(issued), 32'd8);
                issued  = 0;
                written = 0;
                runs++;
                done_cyc = cyc;
                exp_q.delete();
                for (int p = 0; p < 2; p++) for (int k = 0; k < 4; k++) exp_q.push_back(rom_a[k]);
            end
            if (hold && full_pct == 100 && runs > 0) begin
                if (cyc == done_cyc + 1) chk("gap_idle", 32'({idle_a, ce_a}), 32'd2);
                if (cyc == done_cyc + 2) chk("gap_restart_ce", 32'({idle_a, ce_a}), 32'd1);
            end
            @(negedge clk);
            cyc++;
        end
        chk("run_count", 32'(runs), 32'(n_runs));
        if (block_cycles > 0) chk("ce_while_blocked", 32'(ce_blocked), 32'd2);
        start_a = 1'b0;
        full_a  = 1'b1;
        #1;
        chk("idle_after_done", 32'(idle_a), 32'd1);
    endtask

    typedef struct {
        logic        start;
        logic        full_n;
        logic        ce;
        logic [1:0]  addr;
        logic        write;
        logic [15:0] din;
        logic        done;
        logic        idle;
    } vec_t;

    vec_t vecs [12];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int nw;
        int cyc;
        logic [3:0] exp_b;

        vecs[0]  = '{1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 16'd0,  1'b0, 1'b1};
        vecs[1]  = '{1'b0, 1'b1, 1'b1, 2'd0, 1'b0, 16'd0,  1'b0, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 1'b1, 2'd1, 1'b0, 16'd0,  1'b0, 1'b0};
        vecs[3]  = '{1'b0, 1'b1, 1'b1, 2'd2, 1'b1, 16'd10, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 1'b1, 1'b1, 2'd3, 1'b1, 16'd20, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, 1'b1, 2'd0, 1'b1, 16'd30, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, 1'b1, 2'd1, 1'b1, 16'd40, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 1'b1, 1'b1, 2'd2, 1'b1, 16'd10, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 1'b1, 1'b1, 2'd3, 1'b1, 16'd20, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 1'b1, 1'b0, 2'd0, 1'b1, 16'd30, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 1'b1, 1'b0, 2'd0, 1'b1, 16'd40, 1'b1, 1'b0};
        vecs[11] = '{1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 16'd0,  1'b0, 1'b1};

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check_reset_outputs("reset");
        rst_n = 1'b1;

        // Cycle-exact first run, full_n=1
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            start_a = vecs[i].start;
            full_a  = vecs[i].full_n;
            #1;
            chk($sformatf("vec%0d_ctl", i),
                32'({ce_a, write_a, done_a, ready_a, idle_a}),
                32'({vecs[i].ce, vecs[i].write, vecs[i].done, vecs[i].done, vecs[i].idle}));
            if (vecs[i].ce)    chk($sformatf("vec%0d_addr", i), 32'(addr_a), 32'(vecs[i].addr));
            if (vecs[i].write) chk($sformatf("vec%0d_din", i),  32'(din_a),  32'(vecs[i].din));
        end

        run_a(100, 0, 1'b0, 1);
        for (int r = 0; r < 4; r++) run_a(int'($urandom_range(30, 70)), 0, 1'b0, 1);
        run_a(100, 10, 1'b0, 1);
        run_a(100, 0, 1'b1, 3);
        run_a(50, 0, 1'b1, 2);

        // Reset after the 3rd write, then a clean run from address 0
        @(negedge clk);
        start_a = 1'b1;
        full_a  = 1'b1;
        nw  = 0;
        cyc = 0;
        while (nw < 3 && cyc < 50) begin
            #1;
            if (write_a) nw++;
            @(negedge clk);
            start_a = 1'b0;
            cyc++;
        end
        chk("mid_reset_writes_seen", 32'(nw), 32'd3);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        repeat (2) @(negedge clk);
        #1;
        check_reset_outputs("midrst_hold");
        @(negedge clk);
        rst_n = 1'b1;
        run_a(100, 0, 1'b0, 1);

        // MEM_SIZE=1, three passes
        @(negedge clk);
        start_b = 1'b1;
        full_b  = 1'b1;
        for (int c = 0; c < 8; c++) begin
            if (c > 0) start_b = 1'b0;
            #1;
            exp_b = {(c >= 3 && c <= 5), (c == 5), (c == 5), (c == 0 || c >= 6)};
            chk($sformatf("b_ctl_c%0d", c), 32'({write_b, done_b, ready_b, idle_b}), 32'(exp_b));
            if (write_b) chk("b_din", 32'(din_b), 32'd7);
            if (ce_b)    chk("b_addr", 32'(addr_b), 32'd0);
            @(negedge clk);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/bias_seq_ctrl.md
Name: bias_seq_ctrl

Overview:
- Controller that sequences a layer's bias/coefficient ROM and streams its contents to a downstream ap_fifo consumer.
- Runs N_PASSES full sweeps of the ROM per ap_start, with an HLS-style block handshake (ap_start/ap_done/ap_idle/ap_ready).
- Absorbs the 1-cycle ROM read latency and output back-pressure with a 2-entry buffer, sustaining 1 word/cycle.
- Sits between the coefficient ROM instance and the convolution core's bias input FIFO.

Parameters:
- MEM_SIZE, 16, number of ROM words per pass (layer kern_s_k); must be ≥1.
- DATA_WIDTH, 16, coefficient width (coeff_width).
- N_PASSES, 1, sweeps of the ROM per start; must be ≥1.

Ports:
- ap_clk  in  1  clock; all state on rising edge.
- ap_rst_n  in  1  asynchronous, active-low reset.
- ap_start  in  1  start request, sampled in IDLE.
- ap_done  out  1  one-cycle pulse on the final output write.
- ap_idle  out  1  high in IDLE.
- ap_ready  out  1  equal to ap_done.
- rom_address  out  $clog2(MEM_SIZE)  ROM read address.
- rom_ce  out  1  ROM read enable; rom_q is valid the cycle after rom_ce=1.
- rom_q  in  DATA_WIDTH  ROM read data.
- output_V_din  out  DATA_WIDTH  stream data (buffer head).
- output_V_full_n  in  1  downstream not full.
- output_V_write  out  1  stream write; a transfer occurs every cycle it is 1.

Behaviour:
- Reset (async, ap_rst_n=0): state=IDLE, all counters=0, buffer empty, inflight=0.
  - Outputs under reset: ap_done=0, ap_ready=0, rom_ce=0, output_V_write=0, rom_address=0, output_V_din=0, ap_idle=1.
  - Reset mid-run aborts the run immediately; no partial completion.
- FSM states: IDLE, RUN, DRAIN.
  - IDLE: on ap_start=1 at a clock edge, go to RUN; clear addr_cnt and pass_cnt.
  - RUN: issue ROM reads per the credit rule. Once the read of address MEM_SIZE-1 of pass N_PASSES-1 is issued, go to DRAIN.
  - DRAIN: no reads. When the last buffered word is written, assert ap_done and ap_ready for that cycle and go to IDLE.
- Back-to-back starts: if ap_start is still high in the cycle after done, a new run begins (IDLE lasts exactly 1 cycle).
- Read issue (combinational, RUN only):
  - pop = output_V_write.
  - rom_ce = 1 iff (count − pop + inflight) < 2, where count = buffer occupancy (0..2) and inflight = read issued the previous cycle (0/1).
  - rom_address = addr_cnt.
  - On issue, addr_cnt increments. At MEM_SIZE-1 it wraps to 0 and pass_cnt increments.
- Buffer write: when inflight=1, rom_q is pushed into the buffer at that edge. The credit rule guarantees the buffer never overflows.
- Output (ap_fifo rule): output_V_write = (count>0) && output_V_full_n. It is never asserted while full_n=0. output_V_din = head; when empty, din holds its last value.
- Latency: start sampled at edge E0 → rom_ce in cycle 1 → push at E2 → first output_V_write in cycle 3 (if full_n=1).
- Throughput: one write per cycle while full_n=1. Total writes per run = MEM_SIZE×N_PASSES, in address order 0..MEM_SIZE-1, repeated per pass.
- Simultaneous push and pop in one cycle: occupancy is unchanged and order is preserved (FIFO).
- full_n=0: buffer fills to 2 and rom_ce stays 0 until space frees. No word is lost or duplicated.
- MEM_SIZE=1: address stays 0. Each pass issues one read.
- ap_start while in RUN/DRAIN is ignored.

Decomposition:
- Shared package/header: coeff_width, per-layer kern_s_k_N constants (existing layers_sizes/my_types headers); FSM state encoding typedef.
- One sub-module: coeff_fifo2, a 2-entry FIFO with push/pop/count/head, async active-low reset.
- Counters, credit logic and FSM stay in bias_seq_ctrl.

Test Plan:
- MEM_SIZE=4, ROM={10,20,30,40}, N_PASSES=2, full_n=1, 1-cycle start → din sequence 10,20,30,40,10,20,30,40 on 8 consecutive write cycles starting cycle 3; ap_done=ap_ready=1 only with the 8th write; ap_idle=1 the next cycle.
- Same config, full_n toggled pseudo-randomly (≈50%) → identical 8-word sequence; write never 1 while full_n=0; occupancy never >2; rom_ce never 1 when occupancy+inflight would exceed 2.
- full_n=0 from start for 10 cycles, then 1 → exactly 2 rom_ce pulses before release; then 8 writes, no duplicates.
- ap_start held high continuously → runs repeat with exactly 1 idle cycle between ap_done and the next rom_ce; each run emits the 8-word sequence.
- ap_rst_n pulled low after the 3rd write, released, new start → all outputs return to reset values during reset; new run emits the full 10,20,30,40,… sequence from address 0.
- MEM_SIZE=1, ROM={7}, N_PASSES=3 → din 7,7,7 on consecutive cycles; ap_done with the 3rd write.
